// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: program memory walker that decodes MIPS words into class/dest/wen records over valid/ready.
// Optional IFD_JUMP_FOLLOW_EN makes J-class records redirect the pc to their target.
module instr_fetch_decode #(
  parameter int DEPTH = 8,
  parameter int ADDR_W = 3,
  parameter int MAX_ISSUE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_wdata,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [1:0]        out_cls,
  output logic [4:0]        out_dest,
  output logic              out_wen,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;
  localparam logic [ADDR_W:0] DEP = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE = 1;
  localparam logic [7:0] MAX_I = MAX_ISSUE[7:0];
  state_t state, state_nxt;
  logic [31:0] mem [DEPTH];
  logic [ADDR_W:0] len, nxt;
  logic [ADDR_W-1:0] pc;
  logic [7:0] issued;
  logic [31:0] w;
  logic [5:0] op;
  logic [4:0] dd;
  logic [1:0] cc;
  logic ww, hs, last, jmp, go;
  always_ff @(posedge clk)
    if (prog_we && !busy) mem[prog_addr] <= prog_wdata;
  always_comb begin
    w = mem[pc];
    op = w[31:26];
    cc = (op == 6'h00) ? 2'd0 : (op == 6'h02 || op == 6'h03) ? 2'd2 : 2'd1;
    dd = (op == 6'h00) ? w[15:11] : (op == 6'h03) ? 5'd31 : (op == 6'h02) ? 5'd0 : w[20:16];
    ww = (op == 6'h03) | (dd != 5'd0 && cc != 2'd2 && !(op == 6'h04 || op == 6'h05 || op == 6'h2B));
  end
`ifdef IFD_JUMP_FOLLOW_EN
  assign jmp = out_cls == 2'd2;
`else
  assign jmp = 1'b0;
`endif
  // End test runs in ADDR_W+1 bits so a wrapping pc still terminates at len == DEPTH.
  assign nxt = jmp ? {1'b0, out_instr[ADDR_W-1:0]} : {1'b0, pc} + ONE;
  assign last = (nxt >= len) || (issued + 8'd1 == MAX_I);
  assign hs = out_valid & out_ready;
  assign go = (state == IDLE || state == DONE) && start;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (go) state_nxt = (prog_len == '0) ? DONE : FETCH;
    else if (state == FETCH) state_nxt = ISSUE;
    else if (state == ISSUE && hs) state_nxt = last ? DONE : FETCH;
    out_valid = state == ISSUE;
    busy = state == FETCH || state == ISSUE;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len <= '0;
      pc <= '0;
      issued <= '0;
      out_instr <= '0;
      out_pc <= '0;
      out_cls <= '0;
      out_dest <= '0;
      out_wen <= 1'b0;
    end else if (go) begin
      len <= (prog_len > DEP) ? DEP : prog_len;
      pc <= '0;
      issued <= '0;
    end else if (state == FETCH) begin
      out_instr <= w;
      out_pc <= pc;
      out_cls <= cc;
      out_dest <= dd;
      out_wen <= ww;
    end else if (state == ISSUE && hs) begin
      issued <= issued + 8'd1;
      pc <= nxt[ADDR_W-1:0];
    end
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed plus randomized runs checked against a record-list reference model.
module tb_instr_fetch_decode;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int MAXI = 5;
  typedef struct {
    int pc;
    logic [31:0] instr;
    int cls;
    int dest;
    int wen;
  } rec_t;
  logic clk = 1'b0, rst_n = 1'b0, prog_we = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0] prog_wdata = '0;
  logic [AW:0] prog_len = '0;
  logic out_valid, out_wen, busy, done;
  logic [31:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [1:0] out_cls;
  logic [4:0] out_dest;
  logic [31:0] ref_mem [DEPTH];
  logic [5:0] ops [8] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};
  rec_t exp_q[$];
  int n_chk = 0, n_fail = 0;

  instr_fetch_decode #(.DEPTH(DEPTH), .ADDR_W(AW), .MAX_ISSUE(MAXI)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .prog_len(prog_len), .start(start), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_cls(out_cls), .out_dest(out_dest),
    .out_wen(out_wen), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    prog_we = 1'b1;
    prog_addr = a[AW-1:0];
    prog_wdata = d;
    tick;
    prog_we = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic rec_t dec(input int pc, input logic [31:0] w);
    rec_t r;
    int op;
    op = int'(w[31:26]);
    r.pc = pc;
    r.instr = w;
    if (op == 0) begin
      r.cls = 0; r.dest = int'(w[15:11]); r.wen = int'(r.dest != 0);
    end else if (op == 2) begin
      r.cls = 2; r.dest = 0; r.wen = 0;
    end else if (op == 3) begin
      r.cls = 2; r.dest = 31; r.wen = 1;
    end else begin
      r.cls = 1; r.dest = int'(w[20:16]);
      r.wen = int'(!(op == 4 || op == 5 || op == 'h2B) && r.dest != 0);
    end
    return r;
  endfunction

  function automatic void build(input int plen);
    int len, p, n, nx;
    rec_t r;
    len = plen > DEPTH ? DEPTH : plen;
    p = 0;
    n = 0;
    exp_q.delete();
    if (len == 0) return;
    while (1) begin
      r = dec(p, ref_mem[p]);
      exp_q.push_back(r);
      n++;
      nx = p + 1;
`ifdef IFD_JUMP_FOLLOW_EN
      if (r.cls == 2) nx = int'(r.instr[AW-1:0]);
`endif
      if (nx >= len || n == MAXI) break;
      p = nx;
    end
  endfunction

  task automatic run(input int plen, input int stall_idx, input int stall_n, input bit rnd, input bit we_busy);
    int ns;
    build(plen);
    prog_len = plen[AW:0];
    start = 1'b1;
    tick;
    start = 1'b0;
    if (exp_q.size() == 0) begin
      chk("empty_done", 32'(done), 1);
      chk("empty_busy", 32'(busy), 0);
      chk("empty_valid", 32'(out_valid), 0);
      tick;
      chk("empty_valid2", 32'(out_valid), 0);
      return;
    end
    chk("start_busy", 32'(busy), 1);
    chk("start_valid", 32'(out_valid), 0);
    if (we_busy) begin
      prog_we = 1'b1;
      prog_addr = '0;
      prog_wdata = 32'hFFFF_FFFF;
    end
    foreach (exp_q[i]) begin
      tick;
      chk("valid", 32'(out_valid), 1);
      chk("pc", 32'(out_pc), exp_q[i].pc);
      chk("instr", out_instr, exp_q[i].instr);
      chk("cls", 32'(out_cls), exp_q[i].cls);
      chk("dest", 32'(out_dest), exp_q[i].dest);
      chk("wen", 32'(out_wen), exp_q[i].wen);
      ns = rnd ? int'($urandom_range(0, 3)) : (i == stall_idx ? stall_n : 0);
      if (ns > 0) begin
        out_ready = 1'b0;
        repeat (ns) begin
          tick;
          chk("hold_valid", 32'(out_valid), 1);
          chk("hold_instr", out_instr, exp_q[i].instr);
        end
        out_ready = 1'b1;
      end
      tick;
      if (i == exp_q.size() - 1) begin
        chk("end_done", 32'(done), 1);
        chk("end_busy", 32'(busy), 0);
        chk("end_valid", 32'(out_valid), 0);
      end else begin
        chk("gap_valid", 32'(out_valid), 0);
        chk("gap_busy", 32'(busy), 1);
      end
    end
    prog_we = 1'b0;
    tick;
    chk("done_hold", 32'(done), 1);
    chk("idle_valid", 32'(out_valid), 0);
  endtask

  initial begin
    tick;
    tick;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wen", 32'(out_wen), 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", 32'(out_pc), 0);
    chk("rst_dest", 32'(out_dest), 0);
    chk("rst_cls", 32'(out_cls), 0);
    rst_n = 1'b1;
    tick;
    wr(0, 32'h2004_3456);
    wr(1, 32'h00A4_3020);
    wr(2, 32'h8C05_9ABC);
    wr(3, 32'h0812_3456);
    run(4, -1, 0, 1'b0, 1'b0);
    run(4, 1, 5, 1'b0, 1'b0);
    wr(0, 32'hAC05_0000);
    wr(1, 32'h10A4_0002);
    wr(2, 32'h0C00_0001);
    run(3, -1, 0, 1'b0, 1'b0);
    wr(0, 32'h2004_0001);
    wr(1, 32'h2005_0002);
    wr(2, 32'h0800_0000);
    run(3, -1, 0, 1'b0, 1'b0);
    run(0, -1, 0, 1'b0, 1'b0);
    run(3, -1, 0, 1'b0, 1'b1);
    run(3, -1, 0, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) wr(k, {ops[$urandom_range(0, 7)], 26'($urandom)});
    run(12, -1, 0, 1'b0, 1'b0);
    repeat (10) begin
      for (int k = 0; k < DEPTH; k++) wr(k, {ops[$urandom_range(0, 7)], 26'($urandom)});
      run(int'($urandom_range(0, 10)), -1, 0, 1'b1, 1'b0);
    end
    wr(0, 32'h2004_3456);
    wr(1, 32'h00A4_3020);
    wr(2, 32'h8C05_9ABC);
    wr(3, 32'h0812_3456);
    prog_len = 4'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("pre_rst_valid", 32'(out_valid), 1);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_instr", out_instr, 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_dest", 32'(out_dest), 0);
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick;
    run(4, -1, 0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
